// File: rtl/calc_seq_if.sv
// rtl/calc_seq_if.sv - request, calculator and result signal bundle for calc_seq
interface calc_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         use_acc;

  logic [2:0]   calc_op;
  logic [W-1:0] calc_a;
  logic [W-1:0] calc_b;
  logic [W-1:0] calc_r;
  logic         calc_ovf;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic         out_ovf;

  modport master (
    output in_valid, in_op, in_a, in_b, use_acc, out_ready, calc_r, calc_ovf,
    input  in_ready, calc_op, calc_a, calc_b, out_valid, out_r, out_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, use_acc, out_ready, calc_r, calc_ovf,
    output in_ready, calc_op, calc_a, calc_b, out_valid, out_r, out_ovf
  );
endinterface

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - request sequencer and result stage around the calculator
module calc_seq #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_seq_if.slave     bus,
  input  logic          clr,
  output logic [W-1:0]  acc,
  output logic          ovf_sticky,
  output logic [CW-1:0] op_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [2:0]   calc_op_q;
  logic [W-1:0] calc_a_q;
  logic [W-1:0] calc_b_q;
  logic [W-1:0] out_r_q;
  logic         out_ovf_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.calc_op   = calc_op_q;
  assign bus.calc_a    = calc_a_q;
  assign bus.calc_b    = calc_b_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      calc_op_q  <= '0;
      calc_a_q   <= '0;
      calc_b_q   <= '0;
      out_r_q    <= '0;
      out_ovf_q  <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      op_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            calc_op_q <= bus.in_op;
            // acc here is the pre-clear value even if clr is asserted this cycle
            calc_a_q  <= bus.use_acc ? acc : bus.in_a;
            calc_b_q  <= bus.in_b;
            state     <= EXEC;
          end
        end
        EXEC: begin
          out_r_q   <= bus.calc_r;
          out_ovf_q <= bus.calc_ovf;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // clr wins over the capture-time bookkeeping; the result itself is still captured
      if (clr) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
        op_cnt     <= '0;
      end else if (state == EXEC) begin
        acc        <= bus.calc_r;
        ovf_sticky <= ovf_sticky | bus.calc_ovf;
        if (op_cnt != {CW{1'b1}}) begin
          op_cnt <= op_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Sequencing and result stage wrapped around the combinational calculator stage.
- Accepts operation requests over a valid/ready handshake and registers OP/A/B into the calculator.
- Captures the calculator result and overflow flag one cycle later and presents them downstream over a valid/ready handshake.
- Maintains an accumulator for chained operations, a sticky overflow flag and an operation counter.

Parameters:
- W, 16, operand/result width in bits (must match the calculator stage W).
- CW, 8, width of the operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  3  opcode, passed unchanged to the calculator.
- in_a  input  W  operand A (signed).
- in_b  input  W  operand B (signed).
- use_acc  input  1  when set at accept, the accumulator replaces in_a as operand A.
- clr  input  1  synchronous clear of accumulator, sticky flag and counter.
- calc_op  output  3  registered opcode to the calculator.
- calc_a  output  W  registered A to the calculator.
- calc_b  output  W  registered B to the calculator.
- calc_r  input  W  calculator result.
- calc_ovf  input  1  calculator overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_r  output  W  captured result.
- out_ovf  output  1  overflow of this result.
- acc  output  W  accumulator (last captured result).
- ovf_sticky  output  1  OR of all overflows since reset or clr.
- op_cnt  output  CW  completed operations, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - calc_op, calc_a, calc_b, out_r, acc and op_cnt are 0.
  - out_ovf, ovf_sticky and out_valid are 0.
  - in_ready is 1 (IDLE). Inputs are ignored until the first clk edge after deassertion.
- FSM, three states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1 the request is accepted:
    - calc_op <= in_op.
    - calc_a <= (use_acc ? acc : in_a), using the acc value present in the accept cycle.
    - calc_b <= in_b.
    - Next state EXEC.
  - EXEC: in_ready=0, out_valid=0. The calculator output settles during this cycle. At the closing edge:
    - out_r <= calc_r, out_ovf <= calc_ovf, acc <= calc_r.
    - ovf_sticky <= ovf_sticky | calc_ovf.
    - op_cnt <= op_cnt+1, saturating at 2^CW-1.
    - Next state DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready=1 the next state is IDLE; otherwise stay in DONE with out_r/out_ovf held stable.
- Latency and throughput:
  - Accept edge at cycle 0; out_valid asserted from cycle 2.
  - Minimum initiation interval is 3 cycles (accept, EXEC, DONE with out_ready=1). No overlap of requests.
- calc_op, calc_a and calc_b change only on an accepted request and hold otherwise, including through DONE and IDLE.
- in_valid in a non-IDLE state is not accepted. The requester holds its request until in_ready=1.
- clr:
  - Acts in any state at the next edge: acc <= 0, ovf_sticky <= 0, op_cnt <= 0.
  - clr has priority over the EXEC updates of acc, sticky and counter. out_r and out_ovf are still captured normally.
  - clr does not change state, out_valid or calc_* registers.
  - clr in the same cycle as an accept with use_acc=1: calc_a takes the pre-clear acc value.
- Arithmetic:
  - No arithmetic in this block. Results and overflow are taken verbatim from the calculator; widths are W throughout.
  - op_cnt is unsigned and does not wrap.
- Reset mid-operation (EXEC or DONE) aborts immediately to the reset values. The pending result is lost.

Test Plan:
- Basic add: op=000, a=5, b=3 accepted at cycle 0 → calc_a=5, calc_b=3 from cycle 1; out_valid=1 at cycle 2 with out_r=8, out_ovf=0; acc=8; op_cnt=1.
- Chaining: after 8 is in acc, send op=001, use_acc=1, b=2 → calc_a=8, out_r=6, acc=6. Then op=100, use_acc=1, b=10 → out_r=16, op_cnt=3.
- Overflow and sticky (W=16):
  - op=000, a=0x7FFF, b=1 → out_r=0x8000, out_ovf=1, ovf_sticky=1.
  - Next op 1+1 → out_ovf=0, ovf_sticky stays 1.
  - Pulse clr → ovf_sticky=0, acc=0, op_cnt=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid, out_r and calc_* stable; in_ready=0; an in_valid pulse is ignored.
  - Raise out_ready → IDLE next cycle, in_ready=1.
- clr/capture collision: assert clr during the EXEC cycle of 4+4 → out_r=8 captured, but acc=0, op_cnt=0, ovf_sticky=0.
- Reset mid-operation: drop rst_n in EXEC → all outputs are 0 immediately and in_ready=1. After release, a new 2+2 request yields out_r=4, op_cnt=1.
